// File: rtl/cascade_ctrl_pkg.sv
// Shared definitions for the Viola-Jones cascade stage sequencer: state
// encoding, descriptor word offsets and stage_sum load-type codes.
package cascade_ctrl_pkg;

  // Sequencer states (plain constants so legacy code can reuse the encoding)
  typedef logic [3:0] state_t;
  localparam state_t StIdle    = 4'd0;
  localparam state_t StHdr     = 4'd1;
  localparam state_t StNewStg  = 4'd2;
  localparam state_t StFeat    = 4'd3;
  localparam state_t StSettle  = 4'd4;
  localparam state_t StReq     = 4'd5;
  localparam state_t StWaitSum = 4'd6;
  localparam state_t StEval    = 4'd7;
  localparam state_t StDone    = 4'd8;

  // Word offsets inside a stage header and inside a feature record
  localparam logic [1:0] OffH0    = 2'd0;
  localparam logic [1:0] OffH1    = 2'd1;
  localparam logic [1:0] OffLeft  = 2'd0;
  localparam logic [1:0] OffRight = 2'd1;
  localparam logic [1:0] OffThr   = 2'd2;

  // thresholds_type codes, identical to defs.vh LEFT_VAL/RIGHT_VAL/THRESHOLD
  localparam logic [1:0] TypeNone      = 2'd0;
  localparam logic [1:0] TypeLeftVal   = 2'd1;
  localparam logic [1:0] TypeRightVal  = 2'd2;
  localparam logic [1:0] TypeThreshold = 2'd3;

  // Map a feature-record word offset to the type code stage_sum expects
  function automatic logic [1:0] feat_word_type(input logic [1:0] off);
    logic [1:0] t;
    t = TypeNone;
    unique case (off)
      OffLeft:  t = TypeLeftVal;
      OffRight: t = TypeRightVal;
      OffThr:   t = TypeThreshold;
      default:  t = TypeNone;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fp_ge_cmp.sv
// Combinational IEEE-754 single-precision a >= b. Signed zeros compare
// equal; NaN inputs are not supported.
module fp_ge_cmp (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        ge_o
);

  logic a_zero, b_zero, a_neg, b_neg;

  assign a_zero = (a_i[30:0] == 31'd0);
  assign b_zero = (b_i[30:0] == 31'd0);
  assign a_neg  = a_i[31];
  assign b_neg  = b_i[31];

  // Sign-magnitude ordering: magnitude compare flips for two negatives
  always_comb begin
    ge_o = 1'b0;
    if (a_zero && b_zero) begin
      ge_o = 1'b1;
    end else if (a_neg != b_neg) begin
      ge_o = !a_neg;
    end else if (!a_neg) begin
      ge_o = (a_i[30:0] >= b_i[30:0]);
    end else begin
      ge_o = (a_i[30:0] <= b_i[30:0]);
    end
  end

endmodule

// File: rtl/cascade_stage_ctrl.sv
// Cascade stage sequencer: walks one window's descriptors, loads stage_sum,
// requests feature sums and decides pass/reject per stage.
// Optional statistics ports (cycles_o, feats_o) when
// CASCADE_STAGE_CTRL_STATS_EN is defined.
module cascade_stage_ctrl
  import cascade_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned STAGE_W    = 6,
  parameter int unsigned FEAT_W     = 12,
  parameter int unsigned THR_SETTLE = 5
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  base_addr_i,
  input  logic [STAGE_W-1:0] num_stages_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [STAGE_W-1:0] exit_stage_o,
  output logic               cfg_rd_o,
  output logic [ADDR_W-1:0]  cfg_addr_o,
  input  logic [31:0]        cfg_data_i,
  output logic               feat_req_o,
  output logic [FEAT_W-1:0]  feat_idx_o,
  output logic               new_stage_o,
  output logic [31:0]        thresholds_o,
  output logic [1:0]         thresholds_type_o,
  output logic               thresholds_val_o,
  input  logic [31:0]        stage_sum_i,
  input  logic               stage_sum_val_i
`ifdef CASCADE_STAGE_CTRL_STATS_EN
  ,
  output logic [31:0]        cycles_o,
  output logic [FEAT_W-1:0]  feats_o
`endif
);

  state_t             state_q, state_d;
  logic [1:0]         sub_q, sub_d;
  logic [7:0]         settle_q, settle_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [STAGE_W-1:0] num_stages_q, num_stages_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [FEAT_W-1:0]  num_feat_q, num_feat_d;
  logic [FEAT_W-1:0]  feat_cnt_q, feat_cnt_d;
  logic [FEAT_W-1:0]  feat_idx_q, feat_idx_d;
  logic [31:0]        stage_thr_q, stage_thr_d;
  logic [31:0]        stage_sum_q, stage_sum_d;
  logic [1:0]         rd_type_q, rd_type_d;
  logic               pass_q, pass_d;
  logic [STAGE_W-1:0] exit_q, exit_d;
  logic               sum_ge_thr;

  fp_ge_cmp u_fp_ge_cmp (
    .a_i  (stage_sum_q),
    .b_i  (stage_thr_q),
    .ge_o (sum_ge_thr)
  );

  // Next-state logic for the descriptor walk and stage decision
  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    settle_d     = settle_q;
    ptr_d        = ptr_q;
    num_stages_d = num_stages_q;
    stage_d      = stage_q;
    num_feat_d   = num_feat_q;
    feat_cnt_d   = feat_cnt_q;
    feat_idx_d   = feat_idx_q;
    stage_thr_d  = stage_thr_q;
    stage_sum_d  = stage_sum_q;
    rd_type_d    = TypeNone;
    pass_d       = pass_q;
    exit_d       = exit_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          ptr_d        = base_addr_i;
          num_stages_d = num_stages_i;
          stage_d      = '0;
          feat_idx_d   = '0;
          sub_d        = '0;
          pass_d       = 1'b0;
          exit_d       = '0;
          if (num_stages_i == '0) begin
            pass_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StHdr;
          end
        end
      end
      StHdr: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (sub_q == OffH1) begin
          // H0 read in the previous cycle returns now
          num_feat_d = cfg_data_i[FEAT_W-1:0];
          sub_d      = '0;
          state_d    = StNewStg;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      StNewStg: begin
        // H1 (stage threshold) returns in this cycle
        stage_thr_d = cfg_data_i;
        stage_sum_d = '0;
        feat_cnt_d  = '0;
        sub_d       = '0;
        state_d     = (num_feat_q == '0) ? StEval : StFeat;
      end
      StFeat: begin
        ptr_d     = ptr_q + ADDR_W'(1);
        rd_type_d = feat_word_type(sub_q);
        if (sub_q == OffThr) begin
          settle_d = '0;
          state_d  = StSettle;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      StSettle: begin
        // First cycle here is the cycle the THRESHOLD word is presented
        if (settle_q == 8'(THR_SETTLE - 1)) begin
          state_d = StReq;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StReq: begin
        feat_idx_d = feat_idx_q + FEAT_W'(1);
        feat_cnt_d = feat_cnt_q + FEAT_W'(1);
        state_d    = StWaitSum;
      end
      StWaitSum: begin
        if (stage_sum_val_i) begin
          stage_sum_d = stage_sum_i;
          sub_d       = '0;
          state_d     = (feat_cnt_q != num_feat_q) ? StFeat : StEval;
        end
      end
      StEval: begin
        if (!sum_ge_thr) begin
          pass_d  = 1'b0;
          exit_d  = stage_q;
          state_d = StDone;
        end else if (stage_q == num_stages_q - STAGE_W'(1)) begin
          pass_d  = 1'b1;
          exit_d  = num_stages_q;
          state_d = StDone;
        end else begin
          stage_d = stage_q + STAGE_W'(1);
          sub_d   = '0;
          state_d = StHdr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      sub_q        <= '0;
      settle_q     <= '0;
      ptr_q        <= '0;
      num_stages_q <= '0;
      stage_q      <= '0;
      num_feat_q   <= '0;
      feat_cnt_q   <= '0;
      feat_idx_q   <= '0;
      stage_thr_q  <= '0;
      stage_sum_q  <= '0;
      rd_type_q    <= TypeNone;
      pass_q       <= 1'b0;
      exit_q       <= '0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      settle_q     <= settle_d;
      ptr_q        <= ptr_d;
      num_stages_q <= num_stages_d;
      stage_q      <= stage_d;
      num_feat_q   <= num_feat_d;
      feat_cnt_q   <= feat_cnt_d;
      feat_idx_q   <= feat_idx_d;
      stage_thr_q  <= stage_thr_d;
      stage_sum_q  <= stage_sum_d;
      rd_type_q    <= rd_type_d;
      pass_q       <= pass_d;
      exit_q       <= exit_d;
    end
  end

  // Outputs decoded from state; feature words pass straight through
  always_comb begin
    busy_o            = (state_q != StIdle) && (state_q != StDone);
    done_o            = (state_q == StDone);
    pass_o            = pass_q;
    exit_stage_o      = exit_q;
    cfg_rd_o          = (state_q == StHdr) || (state_q == StFeat);
    cfg_addr_o        = ptr_q;
    feat_req_o        = (state_q == StReq);
    feat_idx_o        = feat_idx_q;
    new_stage_o       = (state_q == StNewStg);
    thresholds_val_o  = (rd_type_q != TypeNone);
    thresholds_type_o = rd_type_q;
    thresholds_o      = thresholds_val_o ? cfg_data_i : 32'd0;
  end

`ifdef CASCADE_STAGE_CTRL_STATS_EN
  logic [31:0] cyc_q;

  // Window cycle count: start cycle through the cycle before done, saturating
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q <= '0;
    end else if (state_q == StIdle) begin
      if (start_i) begin
        cyc_q <= 32'd1;
      end
    end else if (busy_o && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycles_o = cyc_q;
  assign feats_o  = feat_idx_q;
`endif

endmodule
